rng_scheduler: RTL



---
 rtl/rng_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rng_scheduler.sv
// rng_scheduler: one shared 8-bit Fibonacci LFSR serving NUM_REQ requesters.
// Requests are arbitrated round-robin. The granted requester gets a value no
// larger than its inclusive limit. Values come from rejection sampling, and an
// AND-mask fallback is used once MAX_TRIES LFSR steps have been spent.
module rng_scheduler #(
  parameter int          NUM_REQ   = 4,
  parameter logic [7:0]  SEED      = 8'h0F,
  parameter int          MAX_TRIES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   limit,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             rand_out,
  output logic                   valid,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);
  localparam logic [3:0]         LAST_TRY  = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, STEP, RESP} state_t;

  state_t           state, state_next;
  logic [7:0]       lfsr, lfsr_next;
  logic [IDX_W-1:0] rr_ptr, winner, pick;
  logic [7:0]       pick_lim, win_lim;
  logic [3:0]       tries;
  logic             step_done;
  logic [7:0]       step_result;

  assign busy = (state != IDLE);

  // Next LFSR value. An all-zero register would lock up, so it reloads SEED.
  always_comb begin
    if (lfsr == 8'h00) lfsr_next = SEED;
    else               lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
  end

  // Round-robin pick: the first set req bit at or above rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every variable written here gets a default first. Otherwise a path
    // that leaves one unassigned would infer a latch.
    int idx;
    idx      = 0;
    pick     = rr_ptr;
    pick_lim = limit[7:0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        pick     = IDX_W'(idx);
        pick_lim = limit[8*idx +: 8];
      end
    end
  end

  // Result of the current STEP cycle and whether it ends the search.
  always_comb begin
    step_done   = 1'b0;
    step_result = 8'h00;
    if (win_lim == 8'h00) begin
      step_done   = 1'b1;
      step_result = 8'h00;
    end else if (lfsr_next <= win_lim) begin
      step_done   = 1'b1;
      step_result = lfsr_next;
    end else if (tries == LAST_TRY) begin
      // Masking with the limit can only clear bits, so the result stays <= limit.
      step_done   = 1'b1;
      step_result = lfsr_next & win_lim;
    end
  end

  // Next-state logic for IDLE -> STEP -> RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = STEP;
      STEP:    if (step_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then updates from values sampled before the edge, whatever order the
    // statements appear in.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: latch the winner, step the LFSR, and register grant/valid/result.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr     <= SEED;
      rr_ptr   <= '0;
      tries    <= 4'd0;
      winner   <= '0;
      win_lim  <= 8'h00;
      rand_out <= 8'h00;
      grant    <= '0;
      valid    <= 1'b0;
    end else begin
      grant <= '0;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner  <= pick;
            win_lim <= pick_lim;
            tries   <= 4'd0;
          end
        end
        STEP: begin
          lfsr  <= lfsr_next;
          tries <= tries + 4'd1;
          if (step_done) begin
            rand_out <= step_result;
            valid    <= 1'b1;
            grant    <= ONE_HOT_0 << winner;
          end
        end
        RESP: begin
          rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
